// File: rtl/exu_div_seq_ctl_pkg.sv
// Shared types for the divider request sequencer: divider packet and sequencer states.
`default_nettype none

package exu_div_seq_ctl_pkg;

   typedef struct packed {
      logic valid;
      logic unsign;
      logic rem;
   } div_pkt_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FIRE = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } div_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/exu_div_seq_ctl_if.sv
// Request, response and divider-side signals of the divide sequencer.
`default_nettype none

interface exu_div_seq_ctl_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) ();
   import exu_div_seq_ctl_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic [XLEN-1:0]  req_dividend;
   logic [XLEN-1:0]  req_divisor;
   logic             req_unsign;
   logic             req_rem;
   logic [TAG_W-1:0] req_tag;

   logic [XLEN-1:0]  div_dividend;
   logic [XLEN-1:0]  div_divisor;
   div_pkt_t         div_dp;
   logic             div_flush;
   logic             div_finish;
   logic [XLEN-1:0]  div_out;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [XLEN-1:0]  rsp_data;
   logic [TAG_W-1:0] rsp_tag;

   modport slave (
      input  req_valid, req_dividend, req_divisor, req_unsign, req_rem, req_tag,
      input  div_finish, div_out, rsp_ready,
      output req_ready, div_dividend, div_divisor, div_dp, div_flush,
      output rsp_valid, rsp_data, rsp_tag
   );

   modport master (
      output req_valid, req_dividend, req_divisor, req_unsign, req_rem, req_tag,
      output div_finish, div_out, rsp_ready,
      input  req_ready, div_dividend, div_divisor, div_dp, div_flush,
      input  rsp_valid, rsp_data, rsp_tag
   );

endinterface

`default_nettype wire

// File: rtl/exu_div_seq_ctl.sv
// Divide request sequencer: issues one request to the divider, collects the tagged
// result, and handles pipeline flush plus a watchdog on a stuck divider.
`default_nettype none

module exu_div_seq_ctl
   import exu_div_seq_ctl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_l,
   exu_div_seq_ctl_if.slave bus,
   input  logic             flush_lower,
   output logic             err_timeout,
   input  logic             err_clr,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   div_seq_state_t   state_q, state_d;
   logic [XLEN-1:0]  dividend_q, dividend_d;
   logic [XLEN-1:0]  divisor_q, divisor_d;
   logic             unsign_q, unsign_d;
   logic             rem_q, rem_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [XLEN-1:0]  rsp_data_q, rsp_data_d;
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] done_q, done_d;

   logic             req_ready_w;
   logic             accept_w;
   logic             wd_expired_w;
   logic             wdog_flush_w;

   // req_ready must not depend on req_valid, so it decodes state and flush only.
   assign req_ready_w  = (state_q == S_IDLE) & ~flush_lower;
   assign accept_w     = bus.req_valid & req_ready_w;
   assign wd_expired_w = (state_q == S_WAIT) && (wd_cnt_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_d      = state_q;
      dividend_d   = dividend_q;
      divisor_d    = divisor_q;
      unsign_d     = unsign_q;
      rem_d        = rem_q;
      tag_d        = tag_q;
      rsp_data_d   = rsp_data_q;
      wd_cnt_d     = wd_cnt_q;
      done_d       = done_q;
      wdog_flush_w = 1'b0;
      err_d        = err_clr ? 1'b0 : err_q;

      case (state_q)
         S_IDLE: begin
            if (accept_w) begin
               dividend_d = bus.req_dividend;
               divisor_d  = bus.req_divisor;
               unsign_d   = bus.req_unsign;
               rem_d      = bus.req_rem;
               tag_d      = bus.req_tag;
               state_d    = S_FIRE;
            end
         end
         S_FIRE: begin
            wd_cnt_d = '0;
            state_d  = flush_lower ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            // Priority: flush over finish over watchdog; a flush suppresses the error.
            if (flush_lower) begin
               state_d = S_IDLE;
            end else if (bus.div_finish) begin
               rsp_data_d = bus.div_out;
               state_d    = S_RESP;
            end else if (wd_expired_w) begin
               wdog_flush_w = 1'b1;
               err_d        = 1'b1;
               state_d      = S_IDLE;
            end
         end
         S_RESP: begin
            if (flush_lower) begin
               state_d = S_IDLE;
            end else if (bus.rsp_ready) begin
               done_d  = done_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= S_IDLE;
         dividend_q <= '0;
         divisor_q  <= '0;
         unsign_q   <= 1'b0;
         rem_q      <= 1'b0;
         tag_q      <= '0;
         rsp_data_q <= '0;
         wd_cnt_q   <= '0;
         err_q      <= 1'b0;
         done_q     <= '0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         unsign_q   <= unsign_d;
         rem_q      <= rem_d;
         tag_q      <= tag_d;
         rsp_data_q <= rsp_data_d;
         wd_cnt_q   <= wd_cnt_d;
         err_q      <= err_d;
         done_q     <= done_d;
      end
   end

   assign bus.req_ready    = req_ready_w;
   assign bus.div_dividend = dividend_q;
   assign bus.div_divisor  = divisor_q;
   assign bus.div_dp       = {state_q == S_FIRE, unsign_q, rem_q};
   assign bus.div_flush    = flush_lower | wdog_flush_w;
   assign bus.rsp_valid    = (state_q == S_RESP);
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_tag      = tag_q;
   assign err_timeout      = err_q;
   assign done_cnt         = done_q;

endmodule

`default_nettype wire
